// File: rtl/i2c_pcf8574_target.sv
// I2C target modelled on the PCF8574 quasi-bidirectional port expander:
// writes latch an 8-bit output port, reads return a snapshot of an 8-bit input port.
module i2c_pcf8574_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h27,
    parameter logic [7:0] RESET_PORT = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] port_in,
    output logic [7:0] port_out,
    output logic       wr_valid,
    output logic       rd_done,
    output logic       active
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK
    } state_t;

    // bit 0 carries scl, bit 1 carries sda
    logic [1:0] line_raw;
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic [1:0] prev_reg;

    logic scl_s, sda_s, scl_p, sda_p;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       sda_low_reg, sda_low_next;
    logic [7:0] port_out_reg, port_out_next;
    logic       wr_valid_reg, wr_valid_next;
    logic       rd_done_reg, rd_done_next;
    logic       active_reg, active_next;

    assign line_raw = {sda, scl};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 2'b11;
            sync_reg <= 2'b11;
            prev_reg <= 2'b11;
        end else begin
            meta_reg <= line_raw;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign scl_s      = sync_reg[0];
    assign sda_s      = sync_reg[1];
    assign scl_p      = prev_reg[0];
    assign sda_p      = prev_reg[1];
    assign scl_rise   = scl_s & ~scl_p;
    assign scl_fall   = ~scl_s & scl_p;
    assign start_cond = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_cond  = scl_s & scl_p & ~sda_p & sda_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 4'd0;
            shift_reg    <= 8'd0;
            sda_low_reg  <= 1'b0;
            port_out_reg <= RESET_PORT;
            wr_valid_reg <= 1'b0;
            rd_done_reg  <= 1'b0;
            active_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            sda_low_reg  <= sda_low_next;
            port_out_reg <= port_out_next;
            wr_valid_reg <= wr_valid_next;
            rd_done_reg  <= rd_done_next;
            active_reg   <= active_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        sda_low_next  = sda_low_reg;
        port_out_next = port_out_reg;
        wr_valid_next = 1'b0;
        rd_done_next  = 1'b0;
        active_next   = active_reg;

        if (start_cond) begin
            state_next   = ADDR;
            bit_cnt_next = 4'd0;
            sda_low_next = 1'b0;
            active_next  = 1'b0;
        end else if (stop_cond) begin
            state_next   = IDLE;
            sda_low_next = 1'b0;
            active_next  = 1'b0;
        end else begin
            case (state_reg)
                ADDR, WRITE: begin
                    if (scl_rise && bit_cnt_reg != 4'd8) begin
                        shift_next   = {shift_reg[6:0], sda_s};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        // the byte only counts once its 8th clock has completed
                        if (state_reg == WRITE) begin
                            port_out_next = shift_reg;
                            wr_valid_next = 1'b1;
                            sda_low_next  = 1'b1;
                            state_next    = WRITE_ACK;
                        end else if (shift_reg[7:1] == DEV_ADDR) begin
                            sda_low_next = 1'b1;
                            active_next  = 1'b1;
                            state_next   = ADDR_ACK;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = 4'd0;
                        if (shift_reg[0]) begin
                            shift_next   = port_in;
                            sda_low_next = ~port_in[7];
                            state_next   = READ;
                        end else begin
                            sda_low_next = 1'b0;
                            state_next   = WRITE;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_low_next = 1'b0;
                        bit_cnt_next = 4'd0;
                        state_next   = WRITE;
                    end
                end
                READ: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_low_next = 1'b0;
                            rd_done_next = 1'b1;
                            state_next   = READ_ACK;
                        end else begin
                            shift_next   = {shift_reg[6:0], 1'b0};
                            sda_low_next = ~shift_reg[6];
                        end
                    end
                end
                READ_ACK: begin
                    // bit_cnt of zero marks a master ACK awaiting the falling edge
                    if (scl_rise) begin
                        if (!sda_s) begin
                            shift_next   = port_in;
                            bit_cnt_next = 4'd0;
                        end else begin
                            active_next = 1'b0;
                            state_next  = IDLE;
                        end
                    end else if (scl_fall && bit_cnt_reg == 4'd0) begin
                        sda_low_next = ~shift_reg[7];
                        state_next   = READ;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // reset releases the line combinationally, without waiting for a clock edge
    assign sda      = (sda_low_reg && !rst) ? 1'b0 : 1'bz;
    assign port_out = port_out_reg;
    assign wr_valid = wr_valid_reg;
    assign rd_done  = rd_done_reg;
    assign active   = active_reg;

endmodule
